l2_lookup_ctrl: RTL and testbench

Sequences the L2 set-RAM read port and the per-way read buffers (lines, tags, hprots, states, evict way) for one lookup at a time. It round-robin arbitrates among `N_REQ` requesters (CPU request, forward, response), issues the RAM read, and strobes buffer capture. It then compares the buffered tags and states against the requested tag and holds a hit/victim result until the consumer acknowledges. It sits between the L2 input queues and the L2 processing FSM.

---
 rtl/l2_lookup_ctrl_pkg.sv | 36 +++
 rtl/l2_rr_arbiter.sv | 40 ++++
 rtl/l2_lookup_ctrl.sv | 130 +++++++++++++
 tb/tb_l2_lookup_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_lookup_ctrl_pkg.sv
// Shared L2 lookup types: set/tag/way/state encodings, lookup FSM states, requester indices.
`ifndef L2_WAYS
`define L2_WAYS 8
`endif

package l2_lookup_ctrl_pkg;

    localparam int L2_NUM_WAYS = `L2_WAYS;
    localparam int L2_SET_W    = 8;
    localparam int L2_TAG_W    = 12;
    localparam int L2_WAY_W    = (L2_NUM_WAYS > 1) ? $clog2(L2_NUM_WAYS) : 1;

    typedef logic [L2_SET_W-1:0] l2_set_t;
    typedef logic [L2_TAG_W-1:0] l2_tag_t;
    typedef logic [L2_WAY_W-1:0] l2_way_t;
    typedef logic [1:0]          state_t;

    localparam state_t INVALID   = 2'd0;
    localparam state_t SHARED    = 2'd1;
    localparam state_t EXCLUSIVE = 2'd2;
    localparam state_t MODIFIED  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD,
        CMP,
        HOLD
    } l2_lookup_state_t;

    localparam int L2_REQ_SRCS = 3;
    localparam int L2_SRC_RSP  = 0;
    localparam int L2_SRC_FWD  = 1;
    localparam int L2_SRC_REQ  = 2;

endpackage

// File: rtl/l2_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid index at or after rr_ptr, wrapping.
module l2_rr_arbiter
    import l2_lookup_ctrl_pkg::*;
#(
    parameter int  N_REQ = L2_REQ_SRCS,
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic             en,
    input  logic [SRC_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [SRC_W-1:0] gnt_idx
);

    logic found;

    // Two upward scans: indices from rr_ptr to the top first, then the wrapped low indices.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        if (en) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && valid[i] && (i >= int'(rr_ptr))) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = SRC_W'(i);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && valid[i] && (i < int'(rr_ptr))) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = SRC_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/l2_lookup_ctrl.sv
// L2 lookup controller: arbitrates one requester, reads the set RAM, strobes the way buffers,
// compares tags/states and holds the hit/victim result until the consumer acknowledges.
module l2_lookup_ctrl
    import l2_lookup_ctrl_pkg::*;
#(
    parameter int  N_REQ   = L2_REQ_SRCS,
    parameter int  L2_WAYS = `L2_WAYS,
    localparam int SRC_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic    [N_REQ-1:0]        req_valid,
    input  l2_set_t [N_REQ-1:0]        req_set,
    input  l2_tag_t [N_REQ-1:0]        req_tag,
    output logic    [N_REQ-1:0]        req_ready,
    output logic                       ram_rd_en,
    output l2_set_t                    ram_rd_set,
    output logic                       buf_ld,
    input  l2_tag_t [L2_WAYS-1:0]      tags_buf,
    input  state_t  [L2_WAYS-1:0]      states_buf,
    input  l2_way_t                    evict_way_buf,
    output logic                       lookup_valid,
    output logic    [SRC_W-1:0]        lookup_src,
    output l2_set_t                    lookup_set,
    output l2_tag_t                    lookup_tag,
    output logic                       lookup_hit,
    output l2_way_t                    lookup_way,
    output logic                       lookup_empty,
    input  logic                       lookup_ack
);

    l2_lookup_state_t state_q, state_d;
    logic [SRC_W-1:0] rr_ptr;
    logic             arb_en;
    logic [N_REQ-1:0] gnt;
    logic [SRC_W-1:0] gnt_idx;
    logic             hit_found, inv_found;
    l2_way_t          hit_way, inv_way;

    // Grants are only offered in IDLE, and never while reset is held.
    assign arb_en     = (state_q == IDLE) && !rst;
    assign req_ready  = gnt;
    assign ram_rd_set = lookup_set;

    l2_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .valid   (req_valid),
        .en      (arb_en),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and the single-cycle RAM/buffer strobes.
    always_comb begin
        state_d      = state_q;
        ram_rd_en    = 1'b0;
        buf_ld       = 1'b0;
        lookup_valid = 1'b0;
        case (state_q)
            IDLE: if (|gnt) state_d = RD;
            RD: begin
                ram_rd_en = 1'b1;
                state_d   = LD;
            end
            LD: begin
                buf_ld  = 1'b1;
                state_d = CMP;
            end
            CMP:  state_d = HOLD;
            HOLD: begin
                lookup_valid = 1'b1;
                if (lookup_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // On grant: latch the winner's set/tag/source and move the pointer past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            lookup_src <= '0;
            lookup_set <= '0;
            lookup_tag <= '0;
        end else if ((state_q == IDLE) && (|gnt)) begin
            rr_ptr     <= (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
            lookup_src <= gnt_idx;
            lookup_set <= req_set[gnt_idx];
            lookup_tag <= req_tag[gnt_idx];
        end
    end

    // Lowest matching valid way, and lowest invalid way, over the buffered set.
    always_comb begin
        hit_found = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = 0; i < L2_WAYS; i++) begin
            if (!hit_found && (states_buf[i] != INVALID) && (tags_buf[i] == lookup_tag)) begin
                hit_found = 1'b1;
                hit_way   = l2_way_t'(i);
            end
            if (!inv_found && (states_buf[i] == INVALID)) begin
                inv_found = 1'b1;
                inv_way   = l2_way_t'(i);
            end
        end
    end

    // Result register: loaded once in CMP, then frozen through HOLD regardless of buffer activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_hit   <= 1'b0;
            lookup_way   <= '0;
            lookup_empty <= 1'b0;
        end else if (state_q == CMP) begin
            lookup_hit   <= hit_found;
            lookup_way   <= hit_found ? hit_way : (inv_found ? inv_way : evict_way_buf);
            lookup_empty <= !hit_found && inv_found;
        end
    end

endmodule

// File: tb/tb_l2_lookup_ctrl.sv
// Bench for l2_lookup_ctrl: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a transaction-level model.
module tb_l2_lookup_ctrl;
    import l2_lookup_ctrl_pkg::*;

    localparam int N  = 3;
    localparam int W  = L2_NUM_WAYS;
    localparam int SW = 2;

    typedef struct packed {
        logic    hit;
        l2_way_t way;
        logic    empty;
    } res_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic    [N-1:0]     req_valid;
    l2_set_t [N-1:0]     req_set;
    l2_tag_t [N-1:0]     req_tag;
    logic    [N-1:0]     req_ready;
    logic                ram_rd_en;
    l2_set_t             ram_rd_set;
    logic                buf_ld;
    l2_tag_t [W-1:0]     tags_buf;
    state_t  [W-1:0]     states_buf;
    l2_way_t             evict_way_buf;
    logic                lookup_valid;
    logic    [SW-1:0]    lookup_src;
    l2_set_t             lookup_set;
    l2_tag_t             lookup_tag;
    logic                lookup_hit;
    l2_way_t             lookup_way;
    logic                lookup_empty;
    logic                lookup_ack;

    l2_lookup_ctrl #(.N_REQ(N), .L2_WAYS(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_set       (req_set),
        .req_tag       (req_tag),
        .req_ready     (req_ready),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_set    (ram_rd_set),
        .buf_ld        (buf_ld),
        .tags_buf      (tags_buf),
        .states_buf    (states_buf),
        .evict_way_buf (evict_way_buf),
        .lookup_valid  (lookup_valid),
        .lookup_src    (lookup_src),
        .lookup_set    (lookup_set),
        .lookup_tag    (lookup_tag),
        .lookup_hit    (lookup_hit),
        .lookup_way    (lookup_way),
        .lookup_empty  (lookup_empty),
        .lookup_ack    (lookup_ack)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // First valid requester at or after rr, wrapping; -1 when none.
    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr + k) % N;
            if (((v >> i) & N'(1)) != '0) return i;
        end
        return -1;
    endfunction

    // Lookup rule: lowest valid tag match wins; else lowest invalid way; else replacement way.
    function automatic res_t ref_result(input l2_tag_t tag, input l2_tag_t [W-1:0] tg,
                                        input state_t [W-1:0] st, input l2_way_t ev);
        res_t r;
        int   inv;
        int   hit;
        inv = -1;
        hit = -1;
        for (int i = W - 1; i >= 0; i--) begin
            if (st[i] == INVALID) inv = i;
            else if (tg[i] == tag) hit = i;
        end
        if (hit >= 0)      r = '{hit: 1'b1, way: l2_way_t'(hit), empty: 1'b0};
        else if (inv >= 0) r = '{hit: 1'b0, way: l2_way_t'(inv), empty: 1'b1};
        else               r = '{hit: 1'b0, way: ev, empty: 1'b0};
        return r;
    endfunction

    // Transaction model: busy flag and cycles elapsed since the grant.
    bit      m_busy = 1'b0;
    int      m_cnt  = 0;
    int      m_rr   = 0;
    int      m_src  = 0;
    l2_set_t m_set  = '0;
    l2_tag_t m_tag  = '0;
    res_t    m_res  = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0;
                m_cnt  = 0;
                m_rr   = 0;
                m_src  = 0;
                m_set  = '0;
                m_tag  = '0;
                m_res  = '0;
            end else if (!m_busy) begin
                int g;
                g = pick(req_valid, m_rr);
                if (g >= 0) begin
                    m_busy = 1'b1;
                    m_cnt  = 1;
                    m_src  = g;
                    for (int r = 0; r < N; r++) begin
                        if (r == g) begin
                            m_set = req_set[r];
                            m_tag = req_tag[r];
                        end
                    end
                    m_rr = (g + 1) % N;
                end
            end else if (m_cnt < 4) begin
                if (m_cnt == 3) m_res = ref_result(m_tag, tags_buf, states_buf, evict_way_buf);
                m_cnt++;
            end else if (lookup_ack) begin
                m_busy = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    logic [N-1:0] exp_rdy;
    int           exp_g;
    initial begin
        forever begin
            @(negedge clk);
            exp_rdy = '0;
            if (!m_busy && !rst) begin
                exp_g = pick(req_valid, m_rr);
                if (exp_g >= 0) exp_rdy = N'(1) << exp_g;
            end
            check("m_req_ready", 32'(req_ready), 32'(exp_rdy));
            check("m_ram_rd_en", 32'(ram_rd_en), 32'(m_busy && m_cnt == 1));
            if (m_busy && m_cnt == 1) check("m_ram_rd_set", 32'(ram_rd_set), 32'(m_set));
            check("m_buf_ld", 32'(buf_ld), 32'(m_busy && m_cnt == 2));
            check("m_lookup_valid", 32'(lookup_valid), 32'(m_busy && m_cnt == 4));
            check("m_lookup_src", 32'(lookup_src), 32'(m_src));
            check("m_lookup_set", 32'(lookup_set), 32'(m_set));
            check("m_lookup_tag", 32'(lookup_tag), 32'(m_tag));
            check("m_lookup_hit", 32'(lookup_hit), 32'(m_res.hit));
            check("m_lookup_way", 32'(lookup_way), 32'(m_res.way));
            check("m_lookup_empty", 32'(lookup_empty), 32'(m_res.empty));
        end
    end

    // Way 5 holds tag 0x3A5 in S; all other ways valid with unrelated tags.
    task automatic bufs_hit5();
        for (int i = 0; i < W; i++) begin
            tags_buf[i]   = l2_tag_t'(12'h100 + i);
            states_buf[i] = MODIFIED;
        end
        tags_buf[5]   = 12'h3A5;
        states_buf[5] = SHARED;
        evict_way_buf = '0;
    endtask

    // One lookup from a single requester, checked against literal expectations; starts and ends in IDLE.
    task automatic do_lookup(input int src, input l2_set_t s, input l2_tag_t t,
                             input bit eh, input l2_way_t ew, input bit ee);
        for (int r = 0; r < N; r++) begin
            if (r == src) begin
                req_set[r] = s;
                req_tag[r] = t;
            end
        end
        req_valid = N'(1) << src;
        @(negedge clk);
        check("d_grant", 32'(req_ready), 32'(N'(1) << src));
        step();
        req_valid = '0;
        @(negedge clk);
        check("d_rd_en", 32'(ram_rd_en), 32'd1);
        check("d_rd_set", 32'(ram_rd_set), 32'(s));
        step();
        @(negedge clk);
        check("d_buf_ld", 32'(buf_ld), 32'd1);
        step();
        @(negedge clk);
        check("d_cmp_valid", 32'(lookup_valid), 32'd0);
        step();
        @(negedge clk);
        check("d_valid", 32'(lookup_valid), 32'd1);
        check("d_hit", 32'(lookup_hit), 32'(eh));
        check("d_way", 32'(lookup_way), 32'(ew));
        check("d_empty", 32'(lookup_empty), 32'(ee));
        check("d_src", 32'(lookup_src), 32'(src));
        lookup_ack = 1'b1;
        step();
        lookup_ack = 1'b0;
        @(negedge clk);
        check("d_valid_after_ack", 32'(lookup_valid), 32'd0);
        step();
    endtask

    int gcnt;
    int gsrc [6];
    int gcyc [6];

    initial begin
        req_valid     = '0;
        req_set       = '0;
        req_tag       = '0;
        lookup_ack    = 1'b0;
        tags_buf      = '0;
        states_buf    = '0;
        evict_way_buf = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check("rst_buf_ld", 32'(buf_ld), 32'd0);
        check("rst_valid", 32'(lookup_valid), 32'd0);
        check("rst_way", 32'(lookup_way), 32'd0);
        step();
        rst = 1'b0;
        step();

        // CPU request hit in way 5.
        bufs_hit5();
        do_lookup(L2_SRC_REQ, 8'h12, 12'h3A5, 1'b1, 3'd5, 1'b0);

        // Miss: ways 0..2 valid, way 3 invalid (its stale tag matches but must not hit).
        for (int i = 0; i < W; i++) begin
            tags_buf[i]   = l2_tag_t'(12'h200 + i);
            states_buf[i] = SHARED;
        end
        tags_buf[3]   = 12'h3A5;
        states_buf[3] = INVALID;
        states_buf[5] = INVALID;
        evict_way_buf = 3'd1;
        do_lookup(L2_SRC_FWD, 8'h40, 12'h3A5, 1'b0, 3'd3, 1'b1);

        // Miss with every way valid: replacement way.
        for (int i = 0; i < W; i++) begin
            tags_buf[i]   = l2_tag_t'(12'h300 + i);
            states_buf[i] = (i % 2 == 0) ? MODIFIED : EXCLUSIVE;
        end
        evict_way_buf = 3'd6;
        do_lookup(L2_SRC_REQ, 8'h7F, 12'h3A5, 1'b0, 3'd6, 1'b0);

        // Round robin with all requesters held and ack held high.
        bufs_hit5();
        for (int r = 0; r < N; r++) begin
            req_set[r] = l2_set_t'(8'h20 + r);
            req_tag[r] = 12'h3A5;
        end
        req_valid  = '1;
        lookup_ack = 1'b1;
        gcnt       = 0;
        for (int c = 0; c < 40 && gcnt < 6; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int r = 0; r < N; r++) if (req_ready[r]) gsrc[gcnt] = r;
                gcyc[gcnt] = c;
                gcnt++;
            end
            step();
        end
        check("rr_grants", 32'(gcnt), 32'd6);
        for (int k = 0; k < 6; k++) check("rr_order", 32'(gsrc[k]), 32'(k % 3));
        for (int k = 1; k < 6; k++) check("rr_period", 32'(gcyc[k] - gcyc[k-1]), 32'd5);
        req_valid = '0;
        repeat (5) step();
        lookup_ack = 1'b0;
        step();

        // Ack withheld 10 cycles with requests pending; buffers scribbled meanwhile.
        bufs_hit5();
        req_valid = '1;
        @(negedge clk);
        check("hold_grant0", 32'(req_ready), 32'b001);
        repeat (4) step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_rd_en", 32'(ram_rd_en), 32'd0);
            check("hold_buf_ld", 32'(buf_ld), 32'd0);
            check("hold_valid", 32'(lookup_valid), 32'd1);
            check("hold_hit", 32'(lookup_hit), 32'd1);
            check("hold_way", 32'(lookup_way), 32'd5);
            check("hold_src", 32'(lookup_src), 32'd0);
            for (int i = 0; i < W; i++) begin
                tags_buf[i]   = 12'h3A5;
                states_buf[i] = INVALID;
            end
            if (k == 9) lookup_ack = 1'b1;
            step();
        end
        lookup_ack = 1'b0;
        @(negedge clk);
        check("hold_next_grant", 32'(req_ready), 32'b010);
        req_valid  = '0;
        lookup_ack = 1'b1;
        repeat (6) step();
        lookup_ack = 1'b0;
        step();

        // Reset during LD aborts; pointer returns to 0.
        bufs_hit5();
        req_tag[1] = 12'h3A5;
        req_set[1] = 8'h55;
        req_valid  = 3'b010;
        @(negedge clk);
        check("abort_grant", 32'(req_ready), 32'b010);
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        check("abort_ld", 32'(buf_ld), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_buf_ld", 32'(buf_ld), 32'd0);
        check("abort_rd_en", 32'(ram_rd_en), 32'd0);
        check("abort_valid", 32'(lookup_valid), 32'd0);
        check("abort_set", 32'(lookup_set), 32'd0);
        check("abort_tag", 32'(lookup_tag), 32'd0);
        check("abort_src", 32'(lookup_src), 32'd0);
        step();
        rst = 1'b0;
        for (int r = 0; r < N; r++) req_tag[r] = 12'h3A5;
        req_valid = '1;
        @(negedge clk);
        check("after_rst_grant", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;
        repeat (3) step();
        @(negedge clk);
        check("after_rst_valid", 32'(lookup_valid), 32'd1);
        check("after_rst_hit", 32'(lookup_hit), 32'd1);
        check("after_rst_way", 32'(lookup_way), 32'd5);
        lookup_ack = 1'b1;
        step();
        lookup_ack = 1'b0;
        step();

        // Randomized traffic, buffers and acks, with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_set[r] = l2_set_t'($urandom);
                req_tag[r] = l2_tag_t'(12'h3A0 + $urandom_range(0, 3));
            end
            for (int i = 0; i < W; i++) begin
                tags_buf[i]   = l2_tag_t'(12'h3A0 + $urandom_range(0, 15));
                states_buf[i] = ($urandom_range(0, 7) == 0) ? INVALID : state_t'($urandom_range(1, 3));
            end
            evict_way_buf = l2_way_t'($urandom);
            lookup_ack    = ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            step();
        end
        rst        = 1'b0;
        req_valid  = '0;
        lookup_ack = 1'b1;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
